// File: rtl/seq_controller_if.sv
// Opcode type package and the sequencer <-> datapath interface.
// The resume signal exists only when SEQ_CTRL_RESUME_EN is defined.
package typedefs;
  typedef enum logic [2:0] {
    HLT = 3'd0,
    SKZ = 3'd1,
    ADD = 3'd2,
    AND = 3'd3,
    XOR = 3'd4,
    LDA = 3'd5,
    STO = 3'd6,
    JMP = 3'd7
  } opcode_t;
endpackage

interface seq_controller_if;
  import typedefs::*;

  opcode_t    opcode;
  logic       zero;
  logic       mem_rd;
  logic       mem_wr;
  logic       load_ir;
  logic       inc_pc;
  logic       load_pc;
  logic       load_ac;
  logic       halt;
  logic [2:0] phase;
`ifdef SEQ_CTRL_RESUME_EN
  logic       resume;

  modport master (
    output opcode, zero, resume,
    input  mem_rd, mem_wr, load_ir, inc_pc, load_pc, load_ac, halt, phase
  );
  modport slave (
    input  opcode, zero, resume,
    output mem_rd, mem_wr, load_ir, inc_pc, load_pc, load_ac, halt, phase
  );
`else
  modport master (
    output opcode, zero,
    input  mem_rd, mem_wr, load_ir, inc_pc, load_pc, load_ac, halt, phase
  );
  modport slave (
    input  opcode, zero,
    output mem_rd, mem_wr, load_ir, inc_pc, load_pc, load_ac, halt, phase
  );
`endif
endinterface

// File: rtl/seq_controller.sv
// Eight-phase instruction sequencer for the accumulator CPU.
// Optional SEQ_CTRL_RESUME_EN: resume input leaves the halted state.
module seq_controller (
  input  logic            clk,
  input  logic            rst_n,
  seq_controller_if.slave bus
);
  import typedefs::*;

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_t;

  phase_t state;
  logic   halted;
  logic   aluop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= INST_ADDR;
      halted <= 1'b0;
    end else if (halted) begin
`ifdef SEQ_CTRL_RESUME_EN
      if (bus.resume) begin
        halted <= 1'b0;
        state  <= INST_ADDR;
      end
`endif
    end else begin
      state <= phase_t'(state + 3'd1);
      // Leaving OP_ADDR lands on OP_FETCH, which is where the halt freezes.
      if (state == OP_ADDR && bus.opcode == HLT)
        halted <= 1'b1;
    end
  end

  always_comb begin
    case (bus.opcode)
      ADD, AND, XOR, LDA: aluop = 1'b1;
      default:            aluop = 1'b0;
    endcase
  end

  always_comb begin
    bus.mem_rd  = 1'b0;
    bus.mem_wr  = 1'b0;
    bus.load_ir = 1'b0;
    bus.inc_pc  = 1'b0;
    bus.load_pc = 1'b0;
    bus.load_ac = 1'b0;
    bus.halt    = 1'b0;
    bus.phase   = state;
    if (halted) begin
      bus.halt = 1'b1;
    end else begin
      case (state)
        INST_ADDR: ;
        INST_FETCH: bus.mem_rd = 1'b1;
        INST_LOAD, IDLE: begin
          bus.mem_rd  = 1'b1;
          bus.load_ir = 1'b1;
        end
        OP_ADDR: begin
          bus.inc_pc = 1'b1;
          bus.halt   = (bus.opcode == HLT);
        end
        OP_FETCH: bus.mem_rd = aluop;
        ALU_OP: begin
          bus.load_ac = aluop;
          bus.mem_rd  = aluop;
          bus.inc_pc  = (bus.opcode == SKZ) && bus.zero;
          bus.load_pc = (bus.opcode == JMP);
        end
        STORE: begin
          bus.load_ac = aluop;
          bus.mem_rd  = aluop;
          bus.inc_pc  = (bus.opcode == JMP);
          bus.load_pc = (bus.opcode == JMP);
          bus.mem_wr  = (bus.opcode == STO);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_controller.sv
// Randomised bench for seq_controller against a phase-counting reference model.
module tb_seq_controller;
  import typedefs::*;

  logic clk;
  logic rst_n;
  seq_controller_if bus ();

  seq_controller dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_cmp;
  int unsigned n_bad;
  int unsigned m_ph;
  bit          m_halt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Strobe vector order: mem_rd, mem_wr, load_ir, inc_pc, load_pc, load_ac, halt
  function automatic logic [6:0] expected(input int unsigned ph, input bit hlt,
                                          input opcode_t op, input logic z);
    bit alu;
    logic rd, wr, ir, inc, lpc, lac, h;
    if (hlt) return 7'b0000001;
    alu = (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
    rd  = (ph >= 1 && ph <= 3) || (alu && ph >= 5);
    wr  = (ph == 7) && (op == STO);
    ir  = (ph == 2) || (ph == 3);
    inc = (ph == 4) || (ph == 6 && op == SKZ && z) || (ph == 7 && op == JMP);
    lpc = (op == JMP) && (ph >= 6);
    lac = alu && (ph >= 6);
    h   = (ph == 4) && (op == HLT);
    return {rd, wr, ir, inc, lpc, lac, h};
  endfunction

  function automatic logic [6:0] observed();
    return {bus.mem_rd, bus.mem_wr, bus.load_ir, bus.inc_pc, bus.load_pc, bus.load_ac, bus.halt};
  endfunction

  task automatic compare(input string tag);
    check({tag, "_phase"}, 32'(bus.phase), 32'(m_ph));
    check({tag, "_strobes"}, 32'(observed()), 32'(expected(m_ph, m_halt, bus.opcode, bus.zero)));
  endtask

  task automatic step(input string tag);
    bit res;
`ifdef SEQ_CTRL_RESUME_EN
    res = bus.resume;
`else
    res = 1'b0;
`endif
    @(posedge clk);
    if (m_halt) begin
      if (res) begin
        m_halt = 1'b0;
        m_ph   = 0;
      end
    end else begin
      if (m_ph == 4 && bus.opcode == HLT) m_halt = 1'b1;
      m_ph = (m_ph + 1) % 8;
    end
    @(negedge clk);
    compare(tag);
  endtask

  task automatic run_instr(input opcode_t op, input logic z, input string tag);
    bus.opcode = op;
    bus.zero   = z;
    repeat (8) step(tag);
  endtask

  task automatic do_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    m_ph   = 0;
    m_halt = 1'b0;
    check({tag, "_async_phase"}, 32'(bus.phase), 32'd0);
    check({tag, "_async_strobes"}, 32'(observed()), 32'd0);
    @(negedge clk);
    compare({tag, "_held"});
    rst_n = 1'b1;
  endtask

  task automatic recover(input string tag);
`ifdef SEQ_CTRL_RESUME_EN
    bus.resume = 1'b1;
    step({tag, "_resume"});
    bus.resume = 1'b0;
    check({tag, "_resume_halt"}, 32'(bus.halt), 32'd0);
`else
    do_reset(tag);
`endif
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    m_ph = 0;
    m_halt = 1'b0;
    rst_n = 1'b0;
    bus.opcode = ADD;
    bus.zero = 1'b0;
`ifdef SEQ_CTRL_RESUME_EN
    bus.resume = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("reset_phase", 32'(bus.phase), 32'd0);
    check("reset_strobes", 32'(observed()), 32'd0);
    rst_n = 1'b1;

    run_instr(ADD, 1'b0, "add_z0");
    run_instr(SKZ, 1'b1, "skz_z1");
    run_instr(SKZ, 1'b0, "skz_z0");
    run_instr(JMP, 1'b0, "jmp");
    run_instr(STO, 1'b1, "sto");
    run_instr(XOR, 1'b1, "xor");

    // Abort mid-instruction in ALU_OP.
    bus.opcode = LDA;
    for (int i = 0; i < 16 && m_ph != 6; i++) step("pre_reset");
    check("reached_phase6", 32'(m_ph), 32'd6);
    do_reset("midreset");
    run_instr(AND, 1'b0, "after_reset");

    // Halt: hold at phase 5 with zero/opcode wiggling.
    run_instr(HLT, 1'b0, "hlt");
    for (int i = 0; i < 22; i++) begin
      bus.opcode = opcode_t'(3'($urandom_range(0, 7)));
      bus.zero   = 1'($urandom);
      step("halted");
    end
    check("halt_phase_frozen", 32'(bus.phase), 32'd5);
    recover("hlt");
    run_instr(ADD, 1'b0, "post_halt");

    for (int n = 0; n < 60; n++) begin
      opcode_t op;
      op = opcode_t'(3'($urandom_range(0, 7)));
`ifdef SEQ_CTRL_RESUME_EN
      bus.resume = (op != HLT) && 1'($urandom);
`endif
      run_instr(op, 1'($urandom), "rand");
      if (op == HLT) begin
        repeat (20 + $urandom_range(0, 4)) step("rand_halted");
        recover("rand");
      end
    end
`ifdef SEQ_CTRL_RESUME_EN
    bus.resume = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
